cci_mpf_tx_buf: RTL and testbench

CCI_MPF_TX_BUF -- requirements
Module: cci_mpf_tx_buf

---
 rtl/cci_mpf_if_pkg.sv | 21 ++
 rtl/cci_mpf_tx_buf_chan.sv | 109 ++++++++++
 rtl/cci_mpf_tx_buf.sv | 50 +++++
 tb/tb_cci_mpf_tx_buf.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/cci_mpf_if_pkg.sv
// Shared width helpers and the channel-slice macro for the CCI MPF TX buffer.
// Every multi-channel bus is a flat vector, with channel i in bits
// [i*W +: W]. CCI_MPF_CHAN_SLICE expresses that slice in one place.

`ifndef CCI_MPF_CHAN_SLICE
`define CCI_MPF_CHAN_SLICE(bus, idx, w) bus[(idx)*(w) +: (w)]
`endif

package cci_mpf_if_pkg;

  // Occupancy must represent 0..DEPTH inclusive, so it needs one more bit than a pointer.
  function automatic int occ_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Pointer width for a power-of-two depth; wrapping is natural overflow.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/cci_mpf_tx_buf_chan.sv
// Single-channel TX FIFO: storage, registered almost-full toward the AFU,
// and a sticky overflow flag.
// Optional feature: CCI_MPF_TX_BUF_BYPASS_EN (empty-FIFO combinational bypass).
//
// Flow control: there is no ready signal on either side. The AFU side is
// valid-only, and the AFU is expected to stop on afu_almfull. A word that
// arrives while the FIFO is full, with no pop in the same cycle, is dropped
// and sets overflow_err. The FIU side is also valid-only: whenever the FIFO
// holds a word and fiu_almfull is low, fiu_valid is high for that cycle and
// the head is consumed unconditionally.

module cci_mpf_tx_buf_chan
  import cci_mpf_if_pkg::*;
#(
  parameter int DATA_WIDTH    = 64,
  parameter int DEPTH         = 16,
  parameter int ALMFULL_SLACK = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               afu_valid,
  input  logic [DATA_WIDTH-1:0]              afu_data,
  output logic                               afu_almfull,
  output logic                               fiu_valid,
  output logic [DATA_WIDTH-1:0]              fiu_data,
  input  logic                               fiu_almfull,
  output logic [occ_width(DEPTH)-1:0]        occupancy,
  output logic                               overflow_err
);

  localparam int OCC_W = occ_width(DEPTH);
  localparam int PTR_W = ptr_width(DEPTH);
  localparam logic [OCC_W-1:0] FULL_CNT = OCC_W'(DEPTH);
  localparam logic [OCC_W-1:0] AF_CNT   = OCC_W'(DEPTH - ALMFULL_SLACK);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [OCC_W-1:0]      count;
  logic                  empty;
  logic                  full;
  logic                  deq;
  logic                  enq;
  logic                  byp;

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);

`ifdef CCI_MPF_TX_BUF_BYPASS_EN
  assign byp = empty && !fiu_almfull && afu_valid && !reset;
`else
  assign byp = 1'b0;
`endif

  // A pop frees the slot in the same cycle, so a full FIFO still accepts a word when it pops.
  assign deq = !empty && !fiu_almfull;
  assign enq = afu_valid && !byp && (!full || deq);

  assign occupancy = count;

  // Head word toward the FIU, or the bypassed AFU word when the FIFO is empty.
  always_comb begin
    fiu_valid = deq || byp;
    fiu_data  = '0;
    if (deq) begin
      fiu_data = mem[rd_ptr];
    end
`ifdef CCI_MPF_TX_BUF_BYPASS_EN
    else if (byp) begin
      fiu_data = afu_data;
    end
`endif
  end

  // Storage array; pointers are reset, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (enq) begin
      mem[wr_ptr] <= afu_data;
    end
  end

  // Pointers, occupancy, registered almost-full and sticky overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      afu_almfull  <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      if (enq) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (deq) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({enq, deq})
        2'b10:   count <= count + OCC_W'(1);
        2'b01:   count <= count - OCC_W'(1);
        default: count <= count;
      endcase
      afu_almfull <= (count >= AF_CNT);
      if (afu_valid && !byp && full && !deq) begin
        overflow_err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cci_mpf_tx_buf.sv
// Multi-channel CCI MPF TX request buffer. Each channel is an independent
// FIFO (cci_mpf_tx_buf_chan), and no state is shared between channels.
// Optional feature: CCI_MPF_TX_BUF_BYPASS_EN. When it is defined, a word
// offered to an empty, unblocked channel passes straight to the FIU in the
// same cycle. When it is undefined, every word spends at least one cycle in
// the FIFO.

module cci_mpf_tx_buf
  import cci_mpf_if_pkg::*;
#(
  parameter int NUM_CHANNELS  = 2,
  parameter int DATA_WIDTH    = 64,
  parameter int DEPTH         = 16,
  parameter int ALMFULL_SLACK = 4
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic [NUM_CHANNELS-1:0]                    afu_tx_valid,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0]         afu_tx_data,
  output logic [NUM_CHANNELS-1:0]                    afu_tx_almfull,
  output logic [NUM_CHANNELS-1:0]                    fiu_tx_valid,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0]         fiu_tx_data,
  input  logic [NUM_CHANNELS-1:0]                    fiu_tx_almfull,
  output logic [NUM_CHANNELS*occ_width(DEPTH)-1:0]   occupancy,
  output logic [NUM_CHANNELS-1:0]                    overflow_err
);

  localparam int OCC_W = occ_width(DEPTH);

  // One independent FIFO per channel; slices follow the flat-bus channel layout.
  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_chan
    cci_mpf_tx_buf_chan #(
      .DATA_WIDTH    (DATA_WIDTH),
      .DEPTH         (DEPTH),
      .ALMFULL_SLACK (ALMFULL_SLACK)
    ) u_chan (
      .clk          (clk),
      .reset        (reset),
      .afu_valid    (afu_tx_valid[g]),
      .afu_data     (`CCI_MPF_CHAN_SLICE(afu_tx_data, g, DATA_WIDTH)),
      .afu_almfull  (afu_tx_almfull[g]),
      .fiu_valid    (fiu_tx_valid[g]),
      .fiu_data     (`CCI_MPF_CHAN_SLICE(fiu_tx_data, g, DATA_WIDTH)),
      .fiu_almfull  (fiu_tx_almfull[g]),
      .occupancy    (`CCI_MPF_CHAN_SLICE(occupancy, g, OCC_W)),
      .overflow_err (overflow_err[g])
    );
  end

endmodule

// File: tb/tb_cci_mpf_tx_buf.sv
// Testbench for cci_mpf_tx_buf (2 channels, 16-bit words, depth 8, slack 2).
// The reference model keeps one word queue per channel. Each cycle it
// decides what should leave the buffer and queues the expected word. A
// negedge monitor pops and compares whenever the DUT presents fiu_tx_valid.

module tb_cci_mpf_tx_buf;

  localparam int NC    = 2;
  localparam int DW    = 16;
  localparam int DEPTH = 8;
  localparam int SLACK = 2;
  localparam int OW    = $clog2(DEPTH) + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [NC-1:0]    afu_tx_valid;
  logic [NC*DW-1:0] afu_tx_data;
  logic [NC-1:0]    afu_tx_almfull;
  logic [NC-1:0]    fiu_tx_valid;
  logic [NC*DW-1:0] fiu_tx_data;
  logic [NC-1:0]    fiu_tx_almfull;
  logic [NC*OW-1:0] occupancy;
  logic [NC-1:0]    overflow_err;

  cci_mpf_tx_buf #(
    .NUM_CHANNELS  (NC),
    .DATA_WIDTH    (DW),
    .DEPTH         (DEPTH),
    .ALMFULL_SLACK (SLACK)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .afu_tx_valid   (afu_tx_valid),
    .afu_tx_data    (afu_tx_data),
    .afu_tx_almfull (afu_tx_almfull),
    .fiu_tx_valid   (fiu_tx_valid),
    .fiu_tx_data    (fiu_tx_data),
    .fiu_tx_almfull (fiu_tx_almfull),
    .occupancy      (occupancy),
    .overflow_err   (overflow_err)
  );

  // ---------------- reference model / scoreboard state ----------------
  logic [DW-1:0] mq    [NC][$];   // words held by the buffer
  logic [DW-1:0] exp_q [NC][$];   // words expected on the FIU side
  int            prev_occ [NC];
  logic          ovf_m    [NC];
  logic          exp_valid[NC];
  int            exp_occ  [NC];
  logic          exp_af   [NC];
  logic          exp_ovf  [NC];
  bit            live;
  int            vec_cnt;
  int            err_cnt;

  task automatic check(input string name, input int ch, input logic [31:0] act,
                       input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s ch%0d @%0t: got 0x%0h, expected 0x%0h", name, ch, $time, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Applies one cycle of stimulus and advances the model by that cycle.
  task automatic drive(input logic [NC-1:0] v, input logic [NC*DW-1:0] d,
                       input logic [NC-1:0] af);
    logic [DW-1:0] w;
    bit            deq;
    bit            byp;
    int            sz;
    @(posedge clk);
    #1;
    afu_tx_valid   = v;
    afu_tx_data    = d;
    fiu_tx_almfull = af;
    for (int ch = 0; ch < NC; ch++) begin
      w            = d[ch*DW +: DW];
      sz           = mq[ch].size();
      exp_occ[ch]  = sz;
      exp_af[ch]   = (prev_occ[ch] >= DEPTH - SLACK);
      prev_occ[ch] = sz;
      exp_ovf[ch]  = ovf_m[ch];
      deq          = (sz > 0) && !af[ch];
      byp          = 1'b0;
`ifdef CCI_MPF_TX_BUF_BYPASS_EN
      byp = (sz == 0) && !af[ch] && v[ch];
`endif
      exp_valid[ch] = deq || byp;
      if (deq) exp_q[ch].push_back(mq[ch].pop_front());
      if (byp) exp_q[ch].push_back(w);
      if (v[ch] && !byp) begin
        if (mq[ch].size() < DEPTH) mq[ch].push_back(w);
        else ovf_m[ch] = 1'b1;
      end
    end
  endtask

  task automatic idle(input int n, input logic [NC-1:0] af);
    repeat (n) drive('0, '0, af);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    live         = 1'b0;
    reset        = 1'b1;
    afu_tx_valid = '0;
    #1;
    for (int ch = 0; ch < NC; ch++) begin
      check("rst_occupancy",    ch, 32'(occupancy[ch*OW +: OW]), 32'd0);
      check("rst_fiu_tx_valid", ch, 32'(fiu_tx_valid[ch]),       32'd0);
      check("rst_fiu_tx_data",  ch, 32'(fiu_tx_data[ch*DW +: DW]), 32'd0);
      check("rst_almfull",      ch, 32'(afu_tx_almfull[ch]),     32'd0);
      check("rst_overflow",     ch, 32'(overflow_err[ch]),       32'd0);
      mq[ch].delete();
      exp_q[ch].delete();
      prev_occ[ch]  = 0;
      ovf_m[ch]     = 1'b0;
      exp_valid[ch] = 1'b0;
      exp_occ[ch]   = 0;
      exp_af[ch]    = 1'b0;
      exp_ovf[ch]   = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    live  = 1'b1;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (live) begin
      for (int ch = 0; ch < NC; ch++) begin
        check("occupancy",      ch, 32'(occupancy[ch*OW +: OW]), 32'(exp_occ[ch]));
        check("afu_tx_almfull", ch, 32'(afu_tx_almfull[ch]),     32'(exp_af[ch]));
        check("overflow_err",   ch, 32'(overflow_err[ch]),       32'(exp_ovf[ch]));
        check("fiu_tx_valid",   ch, 32'(fiu_tx_valid[ch]),       32'(exp_valid[ch]));
        if (fiu_tx_valid[ch]) begin
          if (exp_q[ch].size() == 0) begin
            vec_cnt++;
            err_cnt++;
            $display("FAIL spurious_word ch%0d @%0t: got 0x%0h, expected no word",
                     ch, $time, fiu_tx_data[ch*DW +: DW]);
          end else begin
            check("fiu_tx_data", ch, 32'(fiu_tx_data[ch*DW +: DW]),
                  32'(exp_q[ch].pop_front()));
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [NC-1:0]    v;
    logic [NC-1:0]    af;
    logic [NC*DW-1:0] d;
    int               af_pct;
    reset          = 1'b1;
    afu_tx_valid   = '0;
    afu_tx_data    = '0;
    fiu_tx_almfull = '0;
    live           = 1'b0;
    vec_cnt        = 0;
    err_cnt        = 0;
    do_reset();

    // Three words on channel 0, FIU open; channel 1 idle.
    for (int i = 1; i <= 3; i++) drive(2'b01, {16'h0000, 16'(i)}, 2'b00);
    idle(4, 2'b00);

    // Channel 1 blocked: six words reach the almost-full threshold, nothing leaves.
    for (int i = 0; i < 6; i++) drive(2'b10, {16'(16'h1100 + i), 16'h0000}, 2'b10);
    idle(3, 2'b10);
    idle(10, 2'b00);

    // Channel 0 filled to 8, then an extra word is dropped and overflow sticks.
    for (int i = 0; i < 8; i++) drive(2'b01, {16'h0000, 16'(16'h2000 + i)}, 2'b01);
    drive(2'b01, {16'h0000, 16'hBEEF}, 2'b01);
    idle(3, 2'b01);
    idle(12, 2'b00);

    // Channel 0 full, then a simultaneous push and pop keeps occupancy at 8.
    for (int i = 0; i < 8; i++) drive(2'b01, {16'h0000, 16'(16'h3000 + i)}, 2'b01);
    drive(2'b01, {16'h0000, 16'h00AA}, 2'b00);
    idle(12, 2'b00);

    // Single word into an empty channel 0.
    drive(2'b01, {16'h0000, 16'h1234}, 2'b00);
    idle(3, 2'b00);

    // Five words buffered in both channels, then reset discards them.
    for (int i = 0; i < 5; i++) drive(2'b11, {16'(16'h5100 + i), 16'(16'h5000 + i)}, 2'b11);
    do_reset();
    idle(5, 2'b00);

    // Randomized traffic with phases of light, medium and heavy FIU back-pressure.
    af_pct = 10;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) af_pct = $urandom_range(0, 2) * 40 + 10;
      for (int ch = 0; ch < NC; ch++) begin
        v[ch]  = ($urandom_range(0, 99) < 60);
        af[ch] = ($urandom_range(0, 99) < af_pct);
        d[ch*DW +: DW] = 16'($urandom_range(0, 16'hFFFF));
      end
      drive(v, d, af);
    end
    idle(20, 2'b00);

    for (int ch = 0; ch < NC; ch++) begin
      check("undelivered_words", ch, 32'(exp_q[ch].size()), 32'd0);
    end
    live = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
